// File: rtl/timer_pkg.sv
// Shared encodings for the timer controller: FSM states and run modes.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_if.sv
// Software-facing control/status bundle of the timer controller.
interface timer_ctrl_if #(
    parameter int N_BIT = 4
);
    logic             start;
    logic             stop;
    logic             hold;
    logic             mode;
    logic [N_BIT-1:0] load_val;
    logic [N_BIT-1:0] count;
    logic             tick;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output start, stop, hold, mode, load_val,
        input  count, tick, busy, state
    );

    modport slave (
        input  start, stop, hold, mode, load_val,
        output count, tick, busy, state
    );
endinterface

// File: rtl/count_ld_nbit.sv
// N_BIT down-counter with synchronous load and decrement, async reset to 0.
module count_ld_nbit #(
    parameter int N_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N_BIT-1:0] load_data,
    input  logic             dec,
    output logic [N_BIT-1:0] count
);

    // Load wins over decrement; neither asserted holds the value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_data;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable one-shot/periodic timer: FSM, mode latch and tick register
// sequencing a loadable down-counter.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int N_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    timer_ctrl_if.slave bus
);

    state_t           state_q;
    state_t           state_nxt;
    logic             mode_q;
    logic             mode_nxt;
    logic             tick_q;
    logic             tick_nxt;
    logic             load;
    logic             dec;
    logic [N_BIT-1:0] cnt;

    count_ld_nbit #(.N_BIT(N_BIT)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (bus.load_val),
        .dec       (dec),
        .count     (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ONESHOT;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            mode_q  <= mode_nxt;
            tick_q  <= tick_nxt;
        end
    end

    // Priority at every edge: stop > start > hold > count.
    always_comb begin
        state_nxt = state_q;
        mode_nxt  = mode_q;
        tick_nxt  = 1'b0;
        load      = 1'b0;
        dec       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.stop && bus.start) begin
                    load      = 1'b1;
                    mode_nxt  = bus.mode;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (bus.start) begin
                    load     = 1'b1;
                    mode_nxt = bus.mode;
                end else if (bus.hold) begin
                    state_nxt = ST_PAUSE;
                end else if (cnt == '0) begin
                    tick_nxt = 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    dec = 1'b1;
                end
            end
            ST_PAUSE: begin
                // Leaving PAUSE costs one cycle without a decrement.
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (bus.start) begin
                    load      = 1'b1;
                    mode_nxt  = bus.mode;
                    state_nxt = ST_RUN;
                end else if (!bus.hold) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.count = cnt;
    assign bus.tick  = tick_q;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.state = state_q;

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Controller that sequences an N-bit down-counter as a programmable timer for the cpu15 system.
- Supports one-shot and periodic modes with start, stop (abort) and hold (pause) control.
- Emits a one-cycle terminal tick when the count expires.
- Sits beside the CPU datapath; software-visible registers drive load_val, mode and the control strobes.

Parameters:
- N_BIT, 4, width of the counter and load value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  load load_val and run; level-sampled each edge.
- stop  input  1  abort the run and return to IDLE.
- hold  input  1  freeze the count while high (RUN/PAUSE only).
- mode  input  1  0 = one-shot, 1 = periodic; sampled when a load occurs.
- load_val  input  N_BIT  reload value.
- count  output  N_BIT  current counter value, registered.
- tick  output  1  one-cycle terminal pulse, registered.
- busy  output  1  high when state != IDLE.
- state  output  2  IDLE=0, RUN=1, PAUSE=2 (3 unused).

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, tick=0, busy=0, latched mode=0. Reset takes effect immediately, including mid-run. The first active edge after rst falls is evaluated from IDLE.
- tick defaults to 0 every edge. It is only set by the terminal condition below.
- Priority at each edge: stop > start > hold > count.
- IDLE:
  - stop=1: stay IDLE. Start is ignored, even if asserted simultaneously.
  - Else start=1: count<=load_val, latch mode, go RUN.
  - Else: hold count.
- RUN:
  - stop=1: go IDLE, count holds its current value, no tick.
  - Else start=1: restart with count<=load_val, re-latch mode, stay RUN, no tick.
  - Else hold=1: go PAUSE, count holds.
  - Else count==0: tick<=1.
    - Periodic: count<=load_val (current input value), stay RUN.
    - One-shot: go IDLE, count stays 0.
  - Else: count<=count-1.
- PAUSE:
  - stop=1: go IDLE.
  - Else start=1: reload and go RUN.
  - Else hold=1: stay PAUSE, count frozen.
  - Else: go RUN. No decrement on this edge.
- Latency: if start is sampled at edge E0 with load_val=L:
  - count==L after E0, reaching 0 after edge E0+L.
  - tick is high in the cycle after edge E0+L+1.
  - Periodic period is L+1 cycles.
  - L=0 periodic gives a tick every cycle.
- Arithmetic: unsigned, modulo 2^N_BIT. Decrement never occurs from 0 because the terminal branch takes precedence, so there is no underflow.
- busy is decoded from the registered state. It is 0 in the same cycle that the one-shot terminal tick is high.
- An unused state encoding recovers to IDLE on the next edge.

Decomposition:
- Shared package timer_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE;
  - mode constants MODE_ONESHOT, MODE_PERIODIC.
- One natural sub-module: count_ld_nbit, an N_BIT down-counter with load, load_data, dec, clk, rst and async reset to 0.
- timer_ctrl holds the FSM, mode latch and tick register, and drives load/dec.

Test Plan:
- rst=1 asserted mid-RUN at count=5, between clock edges -> count=0, state=0, busy=0, tick=0 immediately. After rst falls, with no start, outputs stay put.
- One-shot, load_val=3, start for 1 cycle -> count 3,2,1,0. tick=1 for exactly one cycle after the 0 cycle, then state=IDLE, busy=0, count=0.
- Periodic, load_val=2 -> count 2,1,0,2,1,0,... tick high one cycle in every 3. Changing load_val to 4 mid-run takes effect at the next reload.
- Periodic, load_val=5, hold high 2 cycles while count=3 -> state=2 and count=3 for 2 cycles, one extra resume cycle, then decrement continues; tick is delayed 3 cycles relative to no-hold.
- In IDLE, start=1 and stop=1 together -> stays IDLE, count unchanged. In RUN at count=2, start=1 with load_val=7 -> count=7 next cycle, no tick.
- Boundaries: load_val=15 one-shot -> 16 cycles of counting then one tick. load_val=0 periodic -> tick high every cycle, count stays 0. Stop during PAUSE -> IDLE, no tick.
